// File: rtl/spi_slave_ram_resp_if.sv
// SPI pins plus frame status pulses shared between an SPI master and the RAM responder.
interface spi_slave_ram_resp_if;
   logic sck;
   logic csn;
   logic si;
   logic so;
   logic frame_done;
   logic frame_err;

   modport master (output sck, output csn, output si,
                   input  so,  input  frame_done, input frame_err);
   modport slave  (input  sck, input  csn, input  si,
                   output so,  output frame_done, output frame_err);
endinterface

// File: rtl/spi_slave_ram_resp.sv
// SPI mode-0 responder with a local register RAM, oversampling sck/csn/si in the clk domain.
// Frame protocol: csn low frames 8 command bits then DATA_W data bits, MSB first; si sampled on sck rise, so updated on sck fall.
module spi_slave_ram_resp #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 24,
   parameter int DEPTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   spi_slave_ram_resp_if.slave  spi,
   output logic [2:0]           state_dbg
);

   localparam int CMD_BITS   = 8;
   localparam int FRAME_BITS = CMD_BITS + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_CMD_END  = CNT_W'(CMD_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_BITS);

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      IDLE      = 3'd1,
      CMD       = 3'd2,
      WDATA     = 3'd3,
      RDATA     = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t state, state_n;

   // Sync chains reset to 0 so a reset taken mid-frame (csn low) never fakes a csn fall.
   logic [SYNC_STAGES-1:0] sck_sr, csn_sr, si_sr;
   logic sck_q, csn_q;
   logic sck_s, csn_s, si_s;
   logic sck_rise, sck_fall, csn_rise, csn_fall;

   assign sck_s    = sck_sr[SYNC_STAGES-1];
   assign csn_s    = csn_sr[SYNC_STAGES-1];
   assign si_s     = si_sr[SYNC_STAGES-1];
   assign sck_rise =  sck_s & ~sck_q;
   assign sck_fall = ~sck_s &  sck_q;
   assign csn_rise =  csn_s & ~csn_q;
   assign csn_fall = ~csn_s &  csn_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sck_sr <= '0;
         csn_sr <= '0;
         si_sr  <= '0;
         sck_q  <= 1'b0;
         csn_q  <= 1'b0;
      end else begin
         sck_sr <= {sck_sr[SYNC_STAGES-2:0], spi.sck};
         csn_sr <= {csn_sr[SYNC_STAGES-2:0], spi.csn};
         si_sr  <= {si_sr[SYNC_STAGES-2:0],  spi.si};
         sck_q  <= sck_s;
         csn_q  <= csn_s;
      end
   end

   logic [CNT_W-1:0]  bit_cnt;
   logic [7:0]        cmd_r;
   logic [DATA_W-1:0] wdata, rdata;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              so_r, done_r, err_r;
   logic [ADDR_W-1:0] addr;

   assign addr = cmd_r[ADDR_W-1:0];

   logic cnt_clr, cnt_inc, cmd_sh, wd_sh, mem_we, rd_load, rd_sh, so_clr, done_p, err_p;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= WAIT_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      cmd_sh  = 1'b0;
      wd_sh   = 1'b0;
      mem_we  = 1'b0;
      rd_load = 1'b0;
      rd_sh   = 1'b0;
      so_clr  = 1'b0;
      done_p  = 1'b0;
      err_p   = 1'b0;
      case (state)
         WAIT_IDLE: if (csn_s) state_n = IDLE;
         IDLE: begin
            if (csn_fall) begin
               state_n = CMD;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            // csn rise wins over any sck edge detected in the same cycle.
            if (csn_rise) begin
               state_n = IDLE;
               so_clr  = 1'b1;
               if (bit_cnt == CNT_FULL) done_p = 1'b1;
               else                     err_p  = 1'b1;
            end else begin
               case (state)
                  CMD: begin
                     if (sck_rise) begin
                        cmd_sh  = 1'b1;
                        cnt_inc = 1'b1;
                        // cmd_r[6] becomes cmd[7] once this last command bit shifts in.
                        if (bit_cnt == CNT_CMD_LAST) state_n = cmd_r[6] ? WDATA : RDATA;
                     end
                  end
                  WDATA: begin
                     if (sck_rise) begin
                        wd_sh   = 1'b1;
                        cnt_inc = 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                           mem_we  = 1'b1;
                           state_n = DONE;
                        end
                     end
                  end
                  RDATA: begin
                     if (sck_fall) begin
                        if (bit_cnt == CNT_CMD_END) rd_load = 1'b1;
                        else                        rd_sh   = 1'b1;
                     end else if (sck_rise) begin
                        cnt_inc = 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                           state_n = DONE;
                           so_clr  = 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt <= '0;
         cmd_r   <= '0;
         wdata   <= '0;
         rdata   <= '0;
         so_r    <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         done_r <= done_p;
         err_r  <= err_p;
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
         if (cmd_sh) cmd_r <= {cmd_r[6:0], si_s};
         if (wd_sh)  wdata <= {wdata[DATA_W-2:0], si_s};
         if (mem_we) mem[addr] <= {wdata[DATA_W-2:0], si_s};
         if (so_clr) begin
            so_r <= 1'b0;
         end else if (rd_load) begin
            rdata <= mem[addr];
            so_r  <= mem[addr][DATA_W-1];
         end else if (rd_sh) begin
            rdata <= {rdata[DATA_W-2:0], 1'b0};
            so_r  <= rdata[DATA_W-2];
         end
      end
   end

   assign spi.so         = so_r;
   assign spi.frame_done = done_r;
   assign spi.frame_err  = err_r;
   assign state_dbg      = state;

endmodule
